alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that computes a WIDTH-bit ALU operation on one alu_1 slice, LSB first, one bit per clock.
- Owns the operand and result shift registers, the carry register and the iteration counter.
- Start/done handshake; used as the area-minimal ALU option of the multi-cycle MIPS32 datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 011 XOR; latched on accepted start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  WIDTH  final result; held until the next accepted start.
- carry_out  out  1  final carry of ADD/SUB; 0 for logic ops.
- zero  out  1  result == 0; valid with done, then held.
- err  out  1  unsupported alu_op; valid with done, then held.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, result=0, carry_out=0, zero=0, err=0; counter and shift registers cleared.
- States:
  - IDLE: start=1 with a legal op latches a, b, op; clears counter; sets carry_q=1 for SUB, else 0; goes to RUN.
  - IDLE, illegal op: start=1 goes to DONE with result=0 and err=1.
- RUN: each cycle drives the slice with a_sh[0] and a b bit.
  - SUB: slice op forced to 010, b bit inverted, carry_in=carry_q.
  - Other ops: latched op applied directly.
  - Slice result bit shifts into result MSB; a_sh/b_sh shift right.
  - carry_q takes the slice carry_out.
  - Counter increments; at counter==WIDTH-1 the state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0; carry_out=carry_q for ADD/SUB, else 0; zero computed from result; then IDLE.
- Latency: accepted start at edge N. RUN occupies edges N+1..N+WIDTH. done is high in the cycle after edge N+WIDTH+1 (33 edges for WIDTH=32). Back-to-back start is allowed in the cycle after done.
- start while busy or done: ignored, no effect.
- Operand/op inputs changing after acceptance: no effect.
- rst mid-operation: immediate return to IDLE with reset values; no done pulse.
- Carry wrap: carry out of the MSB is reported, never fed back.

Optional Feature:
- Macro ALU_SERIAL_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - For ADD/SUB: ovf = carry into MSB XOR carry out of MSB. The carry into the MSB is captured in the final RUN cycle.
  - ovf is valid with done and held; 0 for logic ops and err.
- Undefined: no ovf port, no capture register.

Decomposition:
- Shared package/header:
  - Opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_XOR=3'b011.
  - State encodings IDLE/RUN/DONE.
- One sub-module instance: alu_1 (the existing 1-bit slice), with carry_in driven from carry_q.
- Controller FSM and shift registers stay in this module.

Test Plan:
- ADD a=5, b=7: done 33 edges after start; result=12, carry_out=0, zero=0, err=0; busy high for 32 cycles.
- ADD a=0xFFFFFFFF, b=1: result=0, carry_out=1, zero=1; with ALU_SERIAL_OVF_EN, ovf=0.
- SUB a=3, b=5: result=0xFFFFFFFE, carry_out=0. SUB a=5, b=3: result=2, carry_out=1. With ALU_SERIAL_OVF_EN, ADD 0x7FFFFFFF+1 gives ovf=1.
- AND/OR/XOR with a=0xF0F0F0F0, b=0xFF00FF00: results 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0 respectively; carry_out=0 each.
- start pulsed again mid-RUN with different operands: ignored; first result unchanged. alu_op=3'b111: done next-but-one cycle with result=0, err=1.
- rst asserted at RUN cycle 10: all outputs to reset values asynchronously; no done pulse. A new start after rst computes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// alu_serial_ctrl_pkg: opcodes, FSM states and opcode helpers for the bit-serial ALU
package alu_serial_ctrl_pkg;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b011;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic logic is_arith(input logic [2:0] op);
      return op == ALU_ADD || op == ALU_SUB;
   endfunction
   function automatic logic is_legal(input logic [2:0] op);
      return is_arith(op) || op == ALU_AND || op == ALU_OR || op == ALU_XOR;
   endfunction
endpackage

// File: rtl/alu_serial_ctrl_alu_1.sv
// alu_1: one-bit ALU slice (AND/OR/XOR/ADD) with carry in/out
module alu_1
   import alu_serial_ctrl_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       cin_i,
   input  logic [2:0] op_i,
   output logic       r_o,
   output logic       cout_o
);
   assign r_o = op_i == ALU_AND ? a_i & b_i :
                op_i == ALU_OR  ? a_i | b_i :
                op_i == ALU_XOR ? a_i ^ b_i :
                op_i == ALU_ADD ? a_i ^ b_i ^ cin_i : 1'b0;
   assign cout_o = (op_i == ALU_ADD) & ((a_i & b_i) | (cin_i & (a_i ^ b_i)));
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial WIDTH-bit ALU sequencer, LSB first; ALU_SERIAL_OVF_EN adds signed overflow output ovf
module alu_serial_ctrl
   import alu_serial_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
`ifdef ALU_SERIAL_OVF_EN
   output logic             ovf,
`endif
   output logic             err
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
   state_t state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
   logic [2:0] op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic carry_q, carry_d, done_q, done_d, cout_q, cout_d, zero_q, zero_d, err_q, err_d;
   logic s_r, s_co;
`ifdef ALU_SERIAL_OVF_EN
   logic cin_msb_q, cin_msb_d, ovf_q, ovf_d;
   assign ovf = ovf_q;
`endif
   assign busy      = state_q == RUN;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = cout_q;
   assign zero      = zero_q;
   assign err       = err_q;

   alu_1 u_slice (
      .a_i   (a_sh_q[0]),
      .b_i   (op_q == ALU_SUB ? ~b_sh_q[0] : b_sh_q[0]),
      .cin_i (carry_q),
      .op_i  (op_q == ALU_SUB ? ALU_ADD : op_q),
      .r_o   (s_r),
      .cout_o(s_co)
   );

   // State and datapath registers; reset clears everything so no done pulse survives rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         op_q     <= ALU_AND;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         done_q   <= 1'b0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         cin_msb_q <= 1'b0;
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         result_q <= result_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         done_q   <= done_d;
         cout_q   <= cout_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
`ifdef ALU_SERIAL_OVF_EN
         cin_msb_q <= cin_msb_d;
         ovf_q     <= ovf_d;
`endif
      end
   end

   // Next state: accept in IDLE (not during the done pulse), shift one bit per RUN cycle, publish flags from DONE
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      result_d = result_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      done_d   = 1'b0;
      cout_d   = cout_q;
      zero_d   = zero_q;
      err_d    = err_q;
`ifdef ALU_SERIAL_OVF_EN
      cin_msb_d = cin_msb_q;
      ovf_d     = ovf_q;
`endif
      case (state_q)
         IDLE: if (start && !done_q) begin
            op_d    = alu_op;
            a_sh_d  = a;
            b_sh_d  = b;
            cnt_d   = '0;
            carry_d = alu_op == ALU_SUB;
            state_d = is_legal(alu_op) ? RUN : DONE;
         end
         RUN: begin
            res_sh_d = {s_r, res_sh_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = s_co;
            cnt_d    = cnt_q + 1'b1;
`ifdef ALU_SERIAL_OVF_EN
            cin_msb_d = cnt_q == LAST ? carry_q : cin_msb_q;
`endif
            state_d  = cnt_q == LAST ? DONE : RUN;
         end
         DONE: begin
            done_d   = 1'b1;
            result_d = is_legal(op_q) ? res_sh_q : '0;
            cout_d   = is_arith(op_q) & carry_q;
            zero_d   = result_d == '0;
            err_d    = !is_legal(op_q);
`ifdef ALU_SERIAL_OVF_EN
            ovf_d    = is_arith(op_q) & (cin_msb_q ^ carry_q);
`endif
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
